// File: rtl/multicycle_main_fsm.sv
// Main sequencing FSM for the multicycle RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and decodes every datapath select and strobe.
module multicycle_main_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       mem_ready,
  input  logic [1:0] Comp,
  output logic       PCWrite,
  output logic       PCSrc,
  output logic       AddrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] WritebackSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  // state          | meaning
  // FETCH          | read instruction at PC, PC <= PC+4 when memory answers
  // DECODE         | ALUOut <= OldPC+imm, dispatch on opcode
  // MEMADR         | ALUOut <= rs1+imm for loads/stores
  // MEMREAD/MEMWB  | load data access, then write rd from memory
  // MEMWRITE       | store data access, ends instruction
  // EXECR/EXECI    | funct-decoded ALU op with rs2 / immediate
  // ALUWB          | rd <= ALUOut
  // JAL/JALRWB     | rd <= OldPC+4 and PC <= ALUOut on the same edge
  // JALR           | ALUOut <= rs1+imm
  // BRANCH         | compare rs1/rs2, PC <= ALUOut when taken
  // LUI/AUIPC      | rd <= ALU result directly
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_JALRWB   = 4'd11,
    S_BRANCH   = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_e     state_q, state_d;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, done, illegal;
  logic       pc_src, addr_src, taken;
  logic [1:0] wb_src, src_a, src_b, alu_op;

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    pc_src    = 1'b0;
    addr_src  = 1'b0;
    taken     = 1'b0;
    wb_src    = 2'b00;
    src_a     = 2'b00;
    src_b     = 2'b00;
    alu_op    = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        src_b    = 2'b10;
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        case (Opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
            done    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = Opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        addr_src = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        wb_src    = 2'b01;
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        addr_src  = 1'b1;
        mem_write = 1'b1;
        done      = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        src_a   = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL, S_JALRWB: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        wb_src    = 2'b10;
        reg_write = 1'b1;
        pc_src    = 1'b1;
        pc_write  = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_JALR: begin
        src_a   = 2'b10;
        src_b   = 2'b01;
        state_d = S_JALRWB;
      end
      S_BRANCH: begin
        src_a  = 2'b10;
        alu_op = 2'b01;
        pc_src = 1'b1;
        done   = 1'b1;
        case (Funct3)
          3'b000:         taken = Comp[0];
          3'b001:         taken = ~Comp[0];
          3'b100, 3'b110: taken = Comp[1];
          3'b101, 3'b111: taken = ~Comp[1];
          default:        illegal = 1'b1;
        endcase
        pc_write = taken;
        state_d  = S_FETCH;
      end
      S_LUI: begin
        src_b     = 2'b01;
        alu_op    = 2'b11;
        wb_src    = 2'b10;
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_AUIPC: begin
        src_a     = 2'b01;
        src_b     = 2'b01;
        wb_src    = 2'b10;
        reg_write = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Strobes are gated by reset directly so a pending memory access drops immediately.
  assign PCWrite      = rst & pc_write;
  assign IRWrite      = rst & ir_write;
  assign RegWrite     = rst & reg_write;
  assign MemRead      = rst & mem_read;
  assign MemWrite     = rst & mem_write;
  assign instr_done   = rst & done;
  assign illegal_op   = rst & illegal;
  assign PCSrc        = pc_src;
  assign AddrSrc      = addr_src;
  assign WritebackSrc = wb_src;
  assign ALUSrcA      = src_a;
  assign ALUSrcB      = src_b;
  assign ALUOp        = alu_op;
  assign state        = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Bench for multicycle_main_fsm: per-instruction expected traces built from the
// instruction class, applied from a vector table, random instructions, and reset corners.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       mem_ready;
  logic [1:0] Comp;
  logic       PCWrite, PCSrc, AddrSrc, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] WritebackSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       instr_done, illegal_op;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  multicycle_main_fsm dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct3(Funct3), .mem_ready(mem_ready),
    .Comp(Comp), .PCWrite(PCWrite), .PCSrc(PCSrc), .AddrSrc(AddrSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .WritebackSrc(WritebackSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcs, adr, mrd, mwr, irw, rgw;
    logic [1:0] wb, sa, sb, op;
    logic       done, ill;
  } obs_t;

  obs_t act;
  assign act = {state, PCWrite, PCSrc, AddrSrc, MemRead, MemWrite, IRWrite, RegWrite,
                WritebackSrc, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal_op};

  obs_t exp_q[$];
  logic mr_q[$];

  function automatic obs_t blank(input int s);
    obs_t o = '0;
    o.st = s[3:0];
    return o;
  endfunction

  function automatic void push(input obs_t o, input logic mr);
    exp_q.push_back(o);
    mr_q.push_back(mr);
  endfunction

  function automatic obs_t jump_wb(input int s);
    obs_t o = blank(s);
    o.sa = 2'b01; o.sb = 2'b10; o.wb = 2'b10;
    o.rgw = 1'b1; o.pcs = 1'b1; o.pcw = 1'b1; o.done = 1'b1;
    return o;
  endfunction

  // Expected per-cycle observation for one instruction, fw fetch waits and mw data waits.
  function automatic void build_trace(input logic [6:0] op, input logic [2:0] f3,
                                      input logic [1:0] cp, input int fw, input int mw);
    obs_t o;
    logic tk;
    for (int i = 0; i <= fw; i++) begin
      o = blank(0); o.mrd = 1'b1; o.sb = 2'b10;
      o.irw = (i == fw); o.pcw = (i == fw);
      push(o, i == fw);
    end
    o = blank(1); o.sa = 2'b01; o.sb = 2'b01;
    case (op)
      7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
      7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111: push(o, 1'($urandom));
      default: begin
        o.ill = 1'b1; o.done = 1'b1;
        push(o, 1'($urandom));
        return;
      end
    endcase
    case (op)
      7'b0000011, 7'b0100011: begin
        o = blank(2); o.sa = 2'b10; o.sb = 2'b01;
        push(o, 1'($urandom));
        for (int i = 0; i <= mw; i++) begin
          if (op == 7'b0000011) begin
            o = blank(3); o.adr = 1'b1; o.mrd = 1'b1;
          end else begin
            o = blank(5); o.adr = 1'b1; o.mwr = 1'b1; o.done = (i == mw);
          end
          push(o, i == mw);
        end
        if (op == 7'b0000011) begin
          o = blank(4); o.wb = 2'b01; o.rgw = 1'b1; o.done = 1'b1;
          push(o, 1'($urandom));
        end
      end
      7'b0110011, 7'b0010011: begin
        o = blank(op[5] ? 6 : 7); o.sa = 2'b10; o.sb = op[5] ? 2'b00 : 2'b01; o.op = 2'b10;
        push(o, 1'($urandom));
        o = blank(8); o.rgw = 1'b1; o.done = 1'b1;
        push(o, 1'($urandom));
      end
      7'b1101111: push(jump_wb(9), 1'($urandom));
      7'b1100111: begin
        o = blank(10); o.sa = 2'b10; o.sb = 2'b01;
        push(o, 1'($urandom));
        push(jump_wb(11), 1'($urandom));
      end
      7'b1100011: begin
        o = blank(12); o.sa = 2'b10; o.op = 2'b01; o.pcs = 1'b1; o.done = 1'b1;
        case (f3)
          3'd0: tk = cp[0];
          3'd1: tk = !cp[0];
          3'd4, 3'd6: tk = cp[1];
          3'd5, 3'd7: tk = !cp[1];
          default: begin tk = 1'b0; o.ill = 1'b1; end
        endcase
        o.pcw = tk;
        push(o, 1'($urandom));
      end
      7'b0110111: begin
        o = blank(13); o.sb = 2'b01; o.op = 2'b11; o.wb = 2'b10; o.rgw = 1'b1; o.done = 1'b1;
        push(o, 1'($urandom));
      end
      default: begin
        o = blank(14); o.sa = 2'b01; o.sb = 2'b01; o.wb = 2'b10; o.rgw = 1'b1; o.done = 1'b1;
        push(o, 1'($urandom));
      end
    endcase
  endfunction

  task automatic check(input string nm, input int cyc, input obs_t e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s cycle %0d: got st=%0d pcw=%b pcs=%b adr=%b mrd=%b mwr=%b irw=%b rgw=%b wb=%b a=%b b=%b op=%b done=%b ill=%b | want st=%0d pcw=%b pcs=%b adr=%b mrd=%b mwr=%b irw=%b rgw=%b wb=%b a=%b b=%b op=%b done=%b ill=%b",
               nm, cyc, act.st, act.pcw, act.pcs, act.adr, act.mrd, act.mwr, act.irw, act.rgw,
               act.wb, act.sa, act.sb, act.op, act.done, act.ill,
               e.st, e.pcw, e.pcs, e.adr, e.mrd, e.mwr, e.irw, e.rgw,
               e.wb, e.sa, e.sb, e.op, e.done, e.ill);
    end
  endtask

  // Called just after a negedge with the DUT in FETCH; returns just after a negedge.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] cp,
                           input int fw, input int mw, input string nm);
    int cyc = 0;
    obs_t e;
    build_trace(op, f3, cp, fw, mw);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      Opcode = op; Funct3 = f3; Comp = cp; mem_ready = mr_q.pop_front();
      #1;
      check(nm, cyc, e);
      cyc++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [1:0] cp;
    int         fw, mw;
    string      nm;
  } vec_t;

  vec_t vecs[$];
  logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
                                7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111};

  obs_t rst_obs;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back('{7'b0010011, 3'd0, 2'b00, 0, 0, "addi"});
    vecs.push_back('{7'b0000011, 3'd2, 2'b00, 0, 2, "lw_wait2"});
    vecs.push_back('{7'b0000011, 3'd2, 2'b00, 0, 0, "lw"});
    vecs.push_back('{7'b0100011, 3'd2, 2'b00, 0, 0, "sw"});
    vecs.push_back('{7'b0100011, 3'd2, 2'b00, 1, 3, "sw_wait"});
    vecs.push_back('{7'b1100011, 3'd0, 2'b01, 0, 0, "beq_taken"});
    vecs.push_back('{7'b1100011, 3'd0, 2'b00, 0, 0, "beq_not"});
    vecs.push_back('{7'b1100011, 3'd1, 2'b00, 0, 0, "bne_taken"});
    vecs.push_back('{7'b1100011, 3'd5, 2'b10, 0, 0, "bge_not"});
    vecs.push_back('{7'b1100011, 3'd6, 2'b10, 0, 0, "bltu_taken"});
    vecs.push_back('{7'b1100011, 3'd2, 2'b11, 0, 0, "branch_f3_010"});
    vecs.push_back('{7'b1100011, 3'd3, 2'b01, 0, 0, "branch_f3_011"});
    vecs.push_back('{7'b1101111, 3'd0, 2'b00, 0, 0, "jal"});
    vecs.push_back('{7'b1100111, 3'd0, 2'b00, 0, 0, "jalr"});
    vecs.push_back('{7'b0110111, 3'd0, 2'b00, 2, 0, "lui_fetchwait"});
    vecs.push_back('{7'b0010111, 3'd0, 2'b00, 0, 0, "auipc"});
    vecs.push_back('{7'b1111111, 3'd0, 2'b00, 0, 0, "illegal_op"});
    vecs.push_back('{7'b0000000, 3'd0, 2'b00, 0, 0, "zero_op"});

    rst_obs = blank(0);
    rst_obs.sb = 2'b10;

    // Reset held two cycles with memory ready: no strobes may leak.
    rst = 1'b0; mem_ready = 1'b1; Opcode = 7'b0110011; Funct3 = 3'd0; Comp = 2'b00;
    @(negedge clk); #1 check("reset_hold", 0, rst_obs);
    @(negedge clk); #1 check("reset_hold", 1, rst_obs);
    @(negedge clk);
    rst = 1'b1;
    run_instr(7'b0110011, 3'd0, 2'b00, 0, 0, "add_after_reset");

    foreach (vecs[i]) run_instr(vecs[i].op, vecs[i].f3, vecs[i].cp, vecs[i].fw, vecs[i].mw, vecs[i].nm);

    // Reset arriving while a store waits on memory.
    Opcode = 7'b0100011; Funct3 = 3'd2; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (state !== 4'd5 || MemWrite !== 1'b1) begin
      failures++;
      $display("FAIL store_wait_entry: got state=%0d MemWrite=%b want state=5 MemWrite=1", state, MemWrite);
    end
    #2 rst = 1'b0;
    #1 check("reset_mid_store", 0, rst_obs);
    @(negedge clk); #1 check("reset_mid_store", 1, rst_obs);
    @(negedge clk);
    rst = 1'b1;
    run_instr(7'b0100011, 3'd2, 2'b00, 0, 0, "store_after_reset");

    for (int n = 0; n < 200; n++) begin
      logic [6:0] op;
      op = ($urandom_range(7) == 0) ? 7'($urandom) : legal_ops[$urandom_range(8)];
      run_instr(op, 3'($urandom), 2'($urandom), $urandom_range(2), $urandom_range(2), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_main_fsm.md
# multicycle_main_fsm

Main controller FSM for the 32-bit RISC-V multicycle core. It sequences the shared datapath (PC, IR/OldPC, register file, single ALU, unified instruction/data memory) through the fetch, decode, execute, memory and writeback steps of each RV32I instruction. It generates every mux select and write strobe. The 4-bit ALU operation is produced by the existing ALU decoder from `ALUOp` plus Funct3/Funct7.

## Interface
- No parameters.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `Opcode` in 7: IR[6:0].
- `Funct3` in 3: IR[14:12].
- `mem_ready` in 1: memory completes the current access this cycle.
- `Comp` in 2: ALU compare flags, valid in the BRANCH cycle. [0] = equal, [1] = less-than (signedness handled by the ALU decoder).
- `PCWrite` out 1: load PC.
- `PCSrc` out 1: PC source. 0 = ALU result, 1 = ALUOut register.
- `AddrSrc` out 1: memory address. 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite` out 1 each: memory strobes.
- `IRWrite` out 1: load IR and OldPC.
- `RegWrite` out 1: register file write.
- `WritebackSrc` out 2: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `ALUSrcA` out 2: 00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALUSrcB` out 2: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `ALUOp` out 2: 00 = add, 01 = compare/subtract, 10 = funct-decoded, 11 = pass B.
- `instr_done` out 1: one-cycle pulse on the last cycle of each instruction.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode or funct3.
- `state` out 4: current state encoding, for debug.

## Operation
Outputs are decoded from the current state, plus `mem_ready`/`Comp` where noted. Any signal not listed for a state is 0.

- **FETCH (0):** AddrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, PCSrc=0.
  - IRWrite = PCWrite = `mem_ready`.
  - Stay in FETCH until `mem_ready`, then go to DECODE.
- **DECODE (1):** ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/JAL target is written to ALUOut). Next state by Opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100111 → JALR
  - 1100011 → BRANCH
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else → FETCH, with illegal_op=1 and instr_done=1.
- **MEMADR (2):** ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if Opcode[5]=0, else MEMWRITE.
- **MEMREAD (3):** AddrSrc=1, MemRead=1. Wait for `mem_ready`, then go to MEMWB.
- **MEMWB (4):** WritebackSrc=01, RegWrite=1, instr_done=1. Go to FETCH.
- **MEMWRITE (5):** AddrSrc=1, MemWrite=1, instr_done=`mem_ready`. Wait for `mem_ready`, then go to FETCH.
- **EXECR (6):** ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- **EXECI (7):** ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
- **ALUWB (8):** WritebackSrc=00, RegWrite=1, instr_done=1. Go to FETCH.
- **JAL (9):** ALUSrcA=01, ALUSrcB=10, ALUOp=00, WritebackSrc=10, RegWrite=1, PCSrc=1, PCWrite=1, instr_done=1. Go to FETCH.
- **JALR (10):** ALUSrcA=10, ALUSrcB=01, ALUOp=00 (target is written to ALUOut). Go to JALRWB.
- **JALRWB (11):** same outputs as JAL. Go to FETCH. Clearing target bit 0 is the datapath's job.
- **BRANCH (12):** ALUSrcA=10, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=taken, instr_done=1. Go to FETCH.
  - taken by Funct3: 000 → Comp[0]; 001 → !Comp[0]; 100/110 → Comp[1]; 101/111 → !Comp[1].
  - Funct3 010/011: not taken, illegal_op=1.
- **LUI (13):** ALUSrcB=01, ALUOp=11, WritebackSrc=10, RegWrite=1, instr_done=1. Go to FETCH.
- **AUIPC (14):** ALUSrcA=01, ALUSrcB=01, ALUOp=00, WritebackSrc=10, RegWrite=1, instr_done=1. Go to FETCH.
- **Unused encoding (15):** go to FETCH on the next edge; all strobes 0.

## Timing
- **Reset:** while `rst`=0, state=FETCH (asynchronously). All strobes (PCWrite, IRWrite, RegWrite, MemRead, MemWrite, instr_done, illegal_op) are forced to 0. Selects take their FETCH values. The first fetch begins on the first rising edge after `rst` rises.
- **Reset mid-access:** `rst` low during MEMWRITE drops MemWrite in the same cycle. The FSM does not wait for the memory to finish.
- **Latency with `mem_ready` held at 1:**
  - branch, JAL, LUI, AUIPC: 3 cycles
  - R-type, I-type ALU, JALR, store: 4 cycles
  - load: 5 cycles
- **Memory wait states:** each cycle with `mem_ready`=0 adds one cycle in FETCH, MEMREAD or MEMWRITE. Strobes stay asserted and addresses stay stable throughout the wait.
- **Branch compare:** `Comp` is sampled combinationally in BRANCH. The PC update happens on the edge that leaves BRANCH.
- **Same-cycle writes:** in JAL/JALRWB, PC and rd are written on the same edge. rd receives OldPC+4 and PC receives ALUOut.

## Test plan
- **Reset then ADD.** `rst` low for 2 cycles, `mem_ready`=1, Opcode 0110011. → State sequence 0,1,6,8,0. IRWrite/PCWrite high only in cycle 1 after reset. RegWrite high in ALUWB with WritebackSrc=00. instr_done pulses once.
- **Load with wait states.** Opcode 0000011, `mem_ready` low for 2 cycles in MEMREAD. → States 0,1,2,3,3,3,4. MemRead=1 and AddrSrc=1 throughout MEMREAD. RegWrite with WritebackSrc=01 in MEMWB. 7 cycles total.
- **Branches.** BEQ with Comp=01 → PCWrite=1, PCSrc=1. BEQ with Comp=00 → PCWrite=0. BGE with Comp=10 → not taken. BLTU with Comp=10 → taken. Funct3=010 → illegal_op pulse, PCWrite=0.
- **Jumps.** JAL: 3 cycles; in cycle 3, RegWrite=PCWrite=1, ALUSrcA=01, ALUSrcB=10, PCSrc=1. JALR: states 0,1,10,11. JALR state drives ALUSrcA=10, ALUSrcB=01.
- **Illegal opcode.** Opcode 1111111 → DECODE returns to FETCH with illegal_op=1 and instr_done=1. No RegWrite, MemWrite or PCWrite.
- **Reset during store wait.** `rst` low while in MEMWRITE with `mem_ready`=0. → MemWrite=0 immediately, state=0. Fetch resumes on the first edge after `rst` rises.
